// File: rtl/tim_apb_arb.sv
// rtl/tim_apb_arb.sv - two-requester round-robin APB master for the timer block
module tim_apb_arb #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_0,
    input  logic        req_write_0,
    input  logic [11:0] req_addr_0,
    input  logic [31:0] req_wdata_0,
    output logic        done_0,
    output logic [31:0] rsp_rdata_0,
    output logic        rsp_err_0,
    input  logic        req_1,
    input  logic        req_write_1,
    input  logic [11:0] req_addr_1,
    input  logic [31:0] req_wdata_1,
    output logic        done_1,
    output logic [31:0] rsp_rdata_1,
    output logic        rsp_err_1,
    output logic        tim_psel,
    output logic        tim_penable,
    output logic        tim_pwrite,
    output logic [11:0] tim_paddr,
    output logic [31:0] tim_pwdata,
    input  logic [31:0] tim_prdata,
    input  logic        tim_pready,
    input  logic        tim_pslverr,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    // The abort fires on the TIMEOUT_CYC-th low-pready ACCESS cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic        r_gnt;
    logic        r_last_gnt;
    logic [7:0]  r_cnt;

    logic        w_win;
    logic        w_finish;
    logic        w_upd_rd;
    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;

    always_comb begin
        w_win       = (req_0 && req_1) ? ~r_last_gnt : req_1;
        w_finish    = (r_state == S_ACCESS) && (tim_pready || (r_cnt == LAST_WAIT));
        // Writes leave read data alone; an abort always clears it.
        w_upd_rd    = !tim_pready || !tim_pwrite;
        w_rdata_nxt = tim_pready ? tim_prdata : 32'd0;
        w_err_nxt   = tim_pready ? tim_pslverr : 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_cnt       <= 8'd0;
            done_0      <= 1'b0;
            done_1      <= 1'b0;
            rsp_rdata_0 <= 32'd0;
            rsp_rdata_1 <= 32'd0;
            rsp_err_0   <= 1'b0;
            rsp_err_1   <= 1'b0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= 12'd0;
            tim_pwdata  <= 32'd0;
            busy        <= 1'b0;
        end else begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_0 || req_1) begin
                        r_gnt      <= w_win;
                        r_last_gnt <= w_win;
                        tim_psel   <= 1'b1;
                        tim_pwrite <= w_win ? req_write_1 : req_write_0;
                        tim_paddr  <= w_win ? req_addr_1  : req_addr_0;
                        tim_pwdata <= w_win ? req_wdata_1 : req_wdata_0;
                        busy       <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    tim_penable <= 1'b1;
                    r_state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_finish) begin
                        if (r_gnt) begin
                            done_1    <= 1'b1;
                            rsp_err_1 <= w_err_nxt;
                            if (w_upd_rd)
                                rsp_rdata_1 <= w_rdata_nxt;
                        end else begin
                            done_0    <= 1'b1;
                            rsp_err_0 <= w_err_nxt;
                            if (w_upd_rd)
                                rsp_rdata_0 <= w_rdata_nxt;
                        end
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        tim_pwrite  <= 1'b0;
                        tim_paddr   <= 12'd0;
                        tim_pwdata  <= 32'd0;
                        r_cnt       <= 8'd0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tim_apb_arb.md
TIM_APB_ARB -- requirements
Module: tim_apb_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, max ACCESS cycles with tim_pready low before abort (range 2..255).
REQ-002 SHALL have one clock and an asynchronous active-low reset:
- sys_clk  in  1  clock; all flops on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
REQ-003 SHALL have these ports for each requester i in {0,1}:
- req_i  in  1  transfer request; held until done_i
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  12  timer register address
- req_wdata_i  in  32  write data
- done_i  out  1  one-cycle completion pulse
- rsp_rdata_i  out  32  read data; held until next done_i
- rsp_err_i  out  1  error status; valid with done_i, held after
REQ-004 SHALL have these APB master ports to timer_top:
- tim_psel  out  1  select
- tim_penable  out  1  enable
- tim_pwrite  out  1  direction
- tim_paddr  out  12  address
- tim_pwdata  out  32  write data
- tim_prdata  in  32  read data
- tim_pready  in  1  slave ready
- tim_pslverr  in  1  slave error
- busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-006 IDLE: req_0 or req_1 high -> latch the winner's write/addr/wdata and grant index, go SETUP; else stay IDLE.
REQ-007 SHALL arbitrate round-robin: one requester -> it wins; both -> winner is the one not granted last (last_gnt); last_gnt updates on each grant.
REQ-008 SETUP: tim_psel=1, tim_penable=0, address/control/wdata from latch; next state ACCESS unconditionally.
REQ-009 ACCESS: tim_psel=1, tim_penable=1; APB signals stable; tim_pready=1 -> capture tim_prdata (reads only) and tim_pslverr, go DONE.
REQ-010 SHALL count ACCESS cycles with tim_pready low (8-bit); count reaching TIMEOUT_CYC -> abort: rsp_err=1, rsp_rdata=0, go DONE.
REQ-011 DONE: done_g=1 for exactly one cycle for granted requester g only; tim_psel=tim_penable=0; next state IDLE; requests not sampled in DONE.
REQ-012 Write completion: rsp_rdata_g unchanged; rsp_err_g=tim_pslverr.
REQ-013 Outside SETUP/ACCESS: tim_psel, tim_penable, tim_pwrite=0, tim_paddr=0, tim_pwdata=0.
REQ-014 Latency with pready=1 in first ACCESS: req in IDLE at cycle N -> SETUP N+1, ACCESS N+2, DONE/done_g N+3, IDLE N+4; minimum 4 cycles per transfer, no back-to-back.
REQ-015 Request deasserted before done: transfer still completes; done still pulses.
REQ-016 Requester inputs changing after grant SHALL not affect the in-flight transfer.

Reset
REQ-017 sys_rst_n low (any state, incl. mid-transfer) SHALL immediately force: FSM=IDLE, all outputs 0, rsp_rdata_i=0, rsp_err_i=0, timeout count=0, last_gnt=1 (requester 0 wins first tie).
REQ-018 Aborted in-flight transfer SHALL produce no done pulse; operation resumes on first rising edge after release.

Verification
REQ-019 Single write: req_0 write TCMP0 (0x0C) data 0x0000_00FF, pready=1 -> tim_paddr=0x0C and tim_pwdata=0xFF in SETUP and ACCESS; done_0 at N+3; rsp_err_0=0; done_1 stays 0.
REQ-020 Read: req_1 read TDR0 (0x04), slave returns 0x1234_5678 after 3 wait cycles -> done_1 at N+6; rsp_rdata_1=0x1234_5678.
REQ-021 Contention: both requests high from reset, each held until its done -> grants 0,1,0,1; every transfer exactly 4 cycles; one idle cycle between transfers.
REQ-022 Timeout: pready held low -> done pulses after TIMEOUT_CYC=16 ACCESS cycles; rsp_err=1; rsp_rdata=0; next transfer unaffected.
REQ-023 Slave error: read of 0x20 with tim_pslverr=1, pready=1 -> rsp_err=1 with done; rsp_err=0 on the following good transfer.
REQ-024 Reset in ACCESS with pready low -> tim_psel=0 and busy=0 without waiting for a clock edge; no done pulse; after release requester 0 wins the first tie.
